ads1115_i2c_target: RTL
=======================

// Module: ads1115_i2c_target
// PURPOSE
//  I2C target (responder) that emulates the ADS1115 ADC at the register level.
//  It answers the on-chip ADC wrapper/I2C master, so closed-loop control can run without the real ADC.
//  Uses: HIL and bench loopback. conv_data_i is fed from a plant model or pattern generator.
//  Sits on the same scl/sda net as the master; drives SDA open-drain via sda_oe_o.
// PARAMETERS
//  ADDRESS      7'h48  7-bit target address matched against the first byte after START
//  SYNC_STAGES  2      flops in the scl_i/sda_i synchronisers (>=2)
// PORTS
//  clk_i        in   1   system clock (27 MHz); SCL must be <= clk_i/16
//  rst_ni       in   1   asynchronous, active-low reset
//  scl_i        in   1   I2C clock from bus (asynchronous)
//  sda_i        in   1   I2C data from bus (asynchronous)
//  sda_oe_o     out  1   1 = pull SDA low; 0 = release (high-Z)
//  conv_data_i  in   16  conversion result returned for pointer 0x00
//  config_o     out  16  config register (pointer 0x01)
//  mux_o        out  3   config_o[14:12], the input-channel select
//  conv_start_o out  1   1-cycle pulse: config committed with bit15 (OS) = 1
//  busy_o       out  1   1 between START and STOP (any address)
// BEHAVIOUR
//  Reset values: sda_oe_o=0, config_o=16'h8583, mux_o=3'b000, conv_start_o=0, busy_o=0, FSM=IDLE.
//  Reset is async, so sda_oe_o releases immediately, including mid-byte.
//  Input conditioning: SYNC_STAGES sync, then a 1-cycle-delayed copy gives rise/fall detects.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  START in any state (repeated START included) -> ADDR, bit_cnt=0, busy_o=1, sda_oe_o=0.
//  STOP in any state -> IDLE, busy_o=0, sda_oe_o=0. Any partial write is discarded.
//  Sampling: SDA is sampled on the synchronised SCL rise, MSB first.
//  Driving: sda_oe_o changes only in the cycle after the synchronised SCL fall.
//  FSM states:
//   IDLE    : wait for START.
//   ADDR    : shift 8 bits. If [7:1]==ADDRESS -> ADDR_ACK; else -> IGNORE (no ACK).
//   ADDR_ACK: drive ACK (oe=1) for the 9th clock.
//            R/W=0 -> PTR. R/W=1 -> snapshot the selected register into tx_q, then RD_DATA.
//   PTR     : shift 8 bits; pointer_q <= byte[1:0]; bits [7:2] ignored; ACK -> PTR_ACK -> WR_DATA.
//   WR_DATA : shift byte. First byte -> wr_hi_q; second byte -> commit. ACK each byte (WR_ACK).
//            Bytes beyond the 2nd are ACKed and dropped.
//   RD_DATA : oe = ~tx_q[bit]. After 8 bits release SDA -> RD_ACK.
//   RD_ACK  : sample master bit on 9th SCL rise. ACK(0) -> RD_DATA with next byte. NACK(1) -> IGNORE.
//   IGNORE  : SDA released; wait for STOP or START.
//  Commit (on SCL fall ending the 2nd data byte's ACK clock):
//   pointer 0x01 -> config_o <= {wr_hi_q, lo}.
//   If that byte pair has bit15=1 -> conv_start_o=1 in the same cycle config_o updates.
//   Pointer 0x00 / 0x02 / 0x03 writes are ACKed and discarded.
//  Read snapshot: 16 bits latched once at the ADDR_ACK->RD_DATA transition, so MSB and LSB are coherent.
//   0x00 -> conv_data_i; 0x01 -> config_o; 0x02 -> 16'h8000; 0x03 -> 16'h7FFF.
//   Byte order MSB then LSB. If the master ACKs the LSB, the same snapshot repeats from MSB.
//  pointer_q persists across transactions; reset value 2'b00.
//  Simultaneous START + SCL edge: START has priority. conv_start_o never lasts >1 cycle.
// TESTING
//  T1 reset: assert rst_ni=0 mid-read while oe=1
//     -> sda_oe_o=0 immediately; config_o=16'h8583; busy_o=0.
//  T2 config write: S 0x90 0x01 0xC3 0x83 P -> 4 ACKs; config_o=16'hC383; mux_o=3'b100;
//     exactly one conv_start_o pulse.
//  T3 coherent read: S 0x90 0x00 Sr 0x91, conv_data_i=16'h733A, switch to 16'h1234 after byte 1
//     -> bytes 0x73, 0x3A; NACK -> SDA released.
//  T4 wrong address: S 0x92 0x01 0xFF 0xFF P -> no ACK; sda_oe_o=0 throughout;
//     config unchanged; no conv_start_o.
//  T5 partial write: S 0x90 0x01 0x45 P -> config_o unchanged; no conv_start_o; busy_o=0 after P.
//  T6 config readback / OS=0: write 0x4383, then S 0x91 read 2
//     -> 0x43, 0x83; no conv_start_o for the write.

Source files
------------

// File: rtl/ads1115_i2c_target.sv
// rtl/ads1115_i2c_target.sv - I2C target emulating the ADS1115 register interface
// Bytes are shifted on SCL rise; SDA drive changes only just after SCL fall.
module ads1115_i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] conv_data_i,
  output logic [15:0] config_o,
  output logic [2:0]  mux_o,
  output logic        conv_start_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_d1_q, sda_d1_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]             bit_cnt_q;
  logic [7:0]             shreg_q, wr_hi_q;
  logic [1:0]             byte_cnt_q, pointer_q;
  logic                   rw_q, ack_q, oe_q, busy_q, conv_start_q;
  logic [15:0]            tx_q, config_q, snap_d;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d1_q;
  assign scl_fall  = ~scl_s & scl_d1_q;
  assign start_det = scl_s & scl_d1_q & sda_d1_q & ~sda_s;
  assign stop_det  = scl_s & scl_d1_q & ~sda_d1_q & sda_s;

  assign sda_oe_o     = oe_q;
  assign config_o     = config_q;
  assign mux_o        = config_q[14:12];
  assign conv_start_o = conv_start_q;
  assign busy_o       = busy_q;

  always_comb begin
    snap_d = 16'h7FFF;
    case (pointer_q)
      2'd0:    snap_d = conv_data_i;
      2'd1:    snap_d = config_q;
      2'd2:    snap_d = 16'h8000;
      default: snap_d = 16'h7FFF;
    endcase
  end

  // Synchronisers idle high so reset release never looks like a START.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_d1_q   <= scl_s;
      sda_d1_q   <= sda_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      wr_hi_q      <= '0;
      byte_cnt_q   <= '0;
      pointer_q    <= '0;
      rw_q         <= 1'b0;
      ack_q        <= 1'b1;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      conv_start_q <= 1'b0;
      tx_q         <= '0;
      config_q     <= 16'h8583;
    end else begin
      conv_start_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        busy_q    <= 1'b1;
        oe_q      <= 1'b0;
      end else if (stop_det) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WR_DATA: begin
            if (scl_rise) begin
              shreg_q   <= {shreg_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= '0;
              if (state_q == ADDR) begin
                if (shreg_q[7:1] == ADDRESS) begin
                  rw_q    <= shreg_q[0];
                  oe_q    <= 1'b1;
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= IGNORE;
                end
              end else if (state_q == PTR) begin
                pointer_q <= shreg_q[1:0];
                oe_q      <= 1'b1;
                state_q   <= PTR_ACK;
              end else begin
                if (byte_cnt_q == 2'd0) wr_hi_q <= shreg_q;
                oe_q    <= 1'b1;
                state_q <= WR_ACK;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (rw_q) begin
              tx_q    <= snap_d;
              oe_q    <= ~snap_d[15];
              state_q <= RD_DATA;
            end else begin
              oe_q    <= 1'b0;
              state_q <= PTR;
            end
          end
          PTR_ACK: if (scl_fall) begin
            oe_q       <= 1'b0;
            byte_cnt_q <= '0;
            state_q    <= WR_DATA;
          end
          WR_ACK: if (scl_fall) begin
            oe_q    <= 1'b0;
            state_q <= WR_DATA;
            if (byte_cnt_q != 2'd2) byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd1 && pointer_q == 2'd1) begin
              config_q     <= {wr_hi_q, shreg_q};
              conv_start_q <= wr_hi_q[7];
            end
          end
          // tx_q rotates so that after 16 bits the snapshot is back at its MSB.
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              tx_q <= {tx_q[14:0], tx_q[15]};
              if (bit_cnt_q == 4'd8) begin
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
                state_q   <= RD_ACK;
              end else begin
                oe_q <= ~tx_q[14];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              ack_q <= sda_s;
            end else if (scl_fall) begin
              if (ack_q) begin
                oe_q    <= 1'b0;
                state_q <= IGNORE;
              end else begin
                oe_q    <= ~tx_q[15];
                state_q <= RD_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
